l1_cache_nway: RTL and testbench
================================

Name: l1_cache_nway

Overview:
- Parametrised successor of the fixed 2-way L1: N-way set-associative, write-back, write-allocate cache with tree pseudo-LRU replacement.
- Sits between the lc3b CPU memory port and the L2 cache port.
- Keeps the same CPU- and L2-side handshakes and the hit/miss pulse outputs.
- Adds a reset, configurable ways/sets, and invalid-way-first victim selection.

Parameters:
WAYS, 4, associativity; power of two, 2..8
SETS, 8, sets per way; power of two, 2..64

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
mem_byte_enable  input  2  byte mask for writes (lc3b_mem_wmask)
mem_address  input  16  CPU byte address
mem_wdata  input  16  CPU write word
mem_resp  output  1  request complete
mem_rdata  output  16  read word
l2_resp  input  1  L2 transaction complete
l2_rdata  input  128  fill line (lc3b_cacheline)
l2_read  output  1  line fill request
l2_write  output  1  line writeback request
l2_address  output  16  line-aligned address; [3:0]=0
l2_wdata  output  128  writeback line
eviction  output  1  high while a dirty writeback is in progress
l1hits_inc  output  1  one-cycle hit pulse
l1misses_inc  output  1  one-cycle miss pulse

Behaviour:
- Address split: offset [3:0]; word select [3:1]; index [4+IDX-1:4] with IDX=log2(SETS); tag = remaining upper bits.
- Reset (async): all valid, dirty and PLRU bits cleared; state IDLE; all outputs 0.
- Reset mid-transaction abandons it; l2_read/l2_write fall immediately.
- States: IDLE, WRITEBACK, FILL.
- IDLE hit (valid and tag match in any way):
  - mem_resp=1 combinationally in the same cycle; mem_rdata is the selected word.
  - l1hits_inc=1, unless this request already missed.
  - PLRU touched at the clock edge.
  - Write: merge the enabled bytes into the word at the clock edge and set dirty.
- mem_read and mem_write both high: treated as a write.
- IDLE miss:
  - l1misses_inc pulses once; set the internal missed flag.
  - Victim = lowest-index invalid way, else the PLRU victim; latched at the edge.
  - Victim valid and dirty -> WRITEBACK, else -> FILL.
- WRITEBACK:
  - l2_write=1, eviction=1, l2_address={victim tag, index, 4'b0}, l2_wdata=victim line.
  - Outputs are held stable until l2_resp, then -> FILL.
- FILL:
  - l2_read=1, l2_address={req tag, index, 4'b0}.
  - On l2_resp: write line to victim way, set tag, valid=1, dirty=0; -> IDLE.
- Miss latency: after the fill, IDLE re-looks up and hits; mem_resp comes 1 cycle after the fill l2_resp, with no l1hits_inc.
- The missed flag clears on mem_resp.
- l2_read and l2_write are never high together.
- CPU drops its request during a miss: the fill still completes; no mem_resp is issued.
- Tree PLRU: WAYS-1 bits per set.
  - Touch points each node away from the accessed way.
  - Victim follows the node bits from the root.

Optional Feature:
Macro L1_CACHE_STATS_EN.
- Defined: adds ports hit_count (output, 32), miss_count (output, 32), wb_count (output, 32).
  - Counters are saturating and cleared by rst_n.
  - They increment with l1hits_inc, l1misses_inc, and each writeback l2_resp respectively.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lc3b_types keeps lc3b_word, lc3b_cacheline and lc3b_mem_wmask.
- Add to lc3b_types: l1_state_t enum (IDLE, WRITEBACK, FILL) and constants L1_OFFSET_BITS=4, L1_LINE_BITS=128.
- Sub-module l1_plru_tree (parameter WAYS), combinational:
  - inputs: set PLRU bits, touch way
  - outputs: next bits, victim way
  - PLRU storage stays in the parent.

Test Plan (WAYS=4, SETS=8; index=addr[6:4]):
- Reset, read 0x0100 -> l1misses_inc x1; l2_read with l2_address 0x0100; l2_resp with line word0=0x1234 -> next cycle mem_resp=1, mem_rdata=0x1234, no hit pulse. Then read 0x0102 -> same-cycle mem_resp, l1hits_inc=1.
- Write 0x0100 with wdata=0xBEEF, be=2'b10 -> mem_resp same cycle. Then read 0x0100 -> 0xBE34.
- Read 0x0000, 0x0080, 0x0100, 0x0180 (set 0, in order), then read 0x0200 -> no writeback; the 0x0000 way is replaced. Re-read 0x0000 -> miss.
- Dirty eviction: write 0x0000 data 0xAAAA be=11, fill the set as above, then read 0x0200 -> l2_write with l2_address 0x0000, eviction=1, l2_wdata word0=0xAAAA. After l2_resp -> l2_read 0x0200.
- Reset asserted while l2_write is high -> l2_write=0 asynchronously. After release, read 0x0000 -> miss, with l2_read (no writeback).
- L1_CACHE_STATS_EN: run the eviction scenario -> wb_count=1; miss_count and hit_count match the pulse totals.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared lc3b memory types plus the L1 cache state encoding and line geometry.
//   lc3b_word       16-bit CPU data word
//   lc3b_cacheline  128-bit L2 line (eight words)
//   lc3b_mem_wmask  2-bit byte enable for CPU writes
//   l1_state_t      IDLE / WRITEBACK / FILL
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef logic [1:0] lc3b_mem_wmask;
  localparam int L1_OFFSET_BITS = 4;
  localparam int L1_LINE_BITS = 128;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} l1_state_t;
endpackage

// File: rtl/l1_plru_tree.sv
// l1_plru_tree: combinational tree pseudo-LRU update and victim selection for one set.
//   i_bits    current node bits (heap order, node n at bit n-1)
//   i_touch   way being accessed
//   o_next    node bits after touching i_touch (each node points away from it)
//   o_victim  way reached by following the node bits from the root
module l1_plru_tree
  import lc3b_types::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         i_bits,
  input  logic [$clog2(WAYS)-1:0] i_touch,
  output logic [WAYS-2:0]         o_next,
  output logic [$clog2(WAYS)-1:0] o_victim
);
  localparam int LVL = $clog2(WAYS);
  // Heap node number is kept in LVL bits: the leading 1 shifts out after the
  // last level, leaving exactly the way number.
  logic [LVL-1:0] w_tn;
  logic [LVL-1:0] w_vn;
  always_comb begin
    o_next = i_bits;
    w_tn = LVL'(1);
    for (int l = 0; l < LVL; l++) begin
      o_next[w_tn - 1'b1] = ~i_touch[LVL-1-l];
      w_tn = LVL'({w_tn, i_touch[LVL-1-l]});
    end
  end
  always_comb begin
    w_vn = LVL'(1);
    for (int l = 0; l < LVL; l++) w_vn = LVL'({w_vn, i_bits[w_vn - 1'b1]});
    o_victim = w_vn;
  end
endmodule

// File: rtl/l1_cache_nway.sv
// l1_cache_nway: N-way set-associative write-back, write-allocate L1 with tree PLRU.
//   CPU side : mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata in,
//              mem_resp/mem_rdata out (hit response is combinational)
//   L2 side  : l2_read/l2_write/l2_address/l2_wdata out, l2_resp/l2_rdata in
//   Status   : eviction (dirty writeback in progress), l1hits_inc, l1misses_inc
//   Optional : L1_CACHE_STATS_EN adds saturating hit_count/miss_count/wb_count
module l1_cache_nway
  import lc3b_types::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  logic [15:0]   mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  input  logic          l2_resp,
  input  lc3b_cacheline l2_rdata,
  output logic          l2_read,
  output logic          l2_write,
  output logic [15:0]   l2_address,
  output lc3b_cacheline l2_wdata,
  output logic          eviction,
  output logic          l1hits_inc,
  output logic          l1misses_inc
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count,
  output logic [31:0]   wb_count
`endif
);
  localparam int IDX = $clog2(SETS);
  localparam int TAGW = 16 - L1_OFFSET_BITS - IDX;
  localparam int WB = $clog2(WAYS);

  l1_state_t               r_state;
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [SETS-1:0][WAYS-1:0] r_dirty;
  logic [SETS-1:0][WAYS-2:0] r_plru;
  logic [TAGW-1:0]         r_tag [WAYS][SETS];
  lc3b_cacheline           r_data [WAYS][SETS];
  logic [WB-1:0]           r_victim;
  logic [IDX-1:0]          r_idx;
  logic [TAGW-1:0]         r_rtag;
  logic                    r_missed;

  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic [6:0]      w_bit;
  logic            w_req;
  logic            w_hit;
  logic            w_miss;
  logic            w_has_inv;
  logic [WB-1:0]   w_hit_way;
  logic [WB-1:0]   w_inv_way;
  logic [WB-1:0]   w_plru_victim;
  logic [WB-1:0]   w_victim;
  logic [WAYS-2:0] w_plru_next;
  lc3b_cacheline   w_line;
  lc3b_word        w_old;
  lc3b_word        w_merged;
  logic            w_unused;

  assign w_idx = mem_address[L1_OFFSET_BITS +: IDX];
  assign w_tag = mem_address[15 -: TAGW];
  assign w_bit = {mem_address[3:1], 4'b0};
  assign w_req = mem_read | mem_write;
  // Accesses are whole words, so the byte-within-word address bit selects nothing.
  assign w_unused = mem_address[0];

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && r_tag[w][w_idx] == w_tag) begin
        w_hit = 1'b1;
        w_hit_way = WB'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WB'(w);
      end
    end
  end

  l1_plru_tree #(.WAYS(WAYS)) u_plru (
    .i_bits  (r_plru[w_idx]),
    .i_touch (w_hit_way),
    .o_next  (w_plru_next),
    .o_victim(w_plru_victim)
  );

  assign w_victim = w_has_inv ? w_inv_way : w_plru_victim;
  assign w_line = r_data[w_hit_way][w_idx];
  assign w_old = w_line[w_bit +: 16];
  assign w_merged = {mem_byte_enable[1] ? mem_wdata[15:8] : w_old[15:8],
                     mem_byte_enable[0] ? mem_wdata[7:0] : w_old[7:0]};

  assign mem_resp = r_state == IDLE && w_req && w_hit;
  assign mem_rdata = mem_resp ? w_old : '0;
  assign w_miss = r_state == IDLE && w_req && !w_hit;
  // A request that missed is answered by the post-fill re-lookup, which is not a hit.
  assign l1hits_inc = mem_resp && !r_missed;
  assign l1misses_inc = w_miss && !r_missed;
  assign l2_write = r_state == WRITEBACK;
  assign l2_read = r_state == FILL;
  assign eviction = l2_write;
  assign l2_address = l2_write ? {r_tag[r_victim][r_idx], r_idx, 4'b0} :
                      l2_read ? {r_rtag, r_idx, 4'b0} : '0;
  assign l2_wdata = l2_write ? r_data[r_victim][r_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_plru <= '0;
      r_victim <= '0;
      r_idx <= '0;
      r_rtag <= '0;
      r_missed <= 1'b0;
    end else if (r_state == IDLE) begin
      if (mem_resp) begin
        r_plru[w_idx] <= w_plru_next;
        if (mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (w_miss) begin
        r_victim <= w_victim;
        r_idx <= w_idx;
        r_rtag <= w_tag;
        r_missed <= 1'b1;
        r_state <= r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim] ? WRITEBACK : FILL;
      end else if (mem_resp || !w_req) begin
        // Also cleared when the CPU abandoned its missed request.
        r_missed <= 1'b0;
      end
    end else if (l2_resp) begin
      if (r_state == WRITEBACK) begin
        r_state <= FILL;
      end else begin
        r_state <= IDLE;
        r_valid[r_idx][r_victim] <= 1'b1;
        r_dirty[r_idx][r_victim] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == FILL && l2_resp) begin
      r_data[r_victim][r_idx] <= l2_rdata;
      r_tag[r_victim][r_idx] <= r_rtag;
    end else if (mem_resp && mem_write) begin
      r_data[w_hit_way][w_idx][w_bit +: 16] <= w_merged;
    end
  end

`ifdef L1_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
      miss_count <= '0;
      wb_count <= '0;
    end else begin
      if (l1hits_inc && ~&hit_count) hit_count <= hit_count + 32'd1;
      if (l1misses_inc && ~&miss_count) miss_count <= miss_count + 32'd1;
      if (l2_write && l2_resp && ~&wb_count) wb_count <= wb_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l1_cache_nway.sv
// tb_l1_cache_nway: directed self-checking bench for l1_cache_nway (WAYS=4, SETS=8).
module tb_l1_cache_nway;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [1:0]   mem_byte_enable = '0;
  logic [15:0]  mem_address = '0;
  logic [15:0]  mem_wdata = '0;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         l2_resp = 1'b0;
  logic [127:0] l2_rdata = '0;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         eviction;
  logic         l1hits_inc;
  logic         l1misses_inc;
`ifdef L1_CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [31:0]  wb_count;
`endif

  int n_chk = 0;
  int n_err = 0;
  int t_hits, t_miss, t_lat, t_fl, g_hits, g_miss;
  logic t_wb, t_ev, t_done, g_both;
  logic [15:0] t_wb_addr, t_wb_w0, t_fill_addr, t_rdata;

  always #5 clk = ~clk;

  l1_cache_nway #(.WAYS(4), .SETS(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .eviction(eviction), .l1hits_inc(l1hits_inc), .l1misses_inc(l1misses_inc)
`ifdef L1_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // L2 backing content: word k of the line at a is a + 0x1134 + k.
  function automatic logic [127:0] fl(input logic [15:0] a);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = a + 16'h1134 + 16'(k);
    return r;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    l2_resp = 1'b0;
    g_hits = 0;
    g_miss = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One CPU request, served by a one-cycle-pulse L2 model, until mem_resp.
  task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] be);
    int c_fill;
    t_hits = 0; t_miss = 0; t_wb = 0; t_ev = 0; t_wb_addr = '0; t_wb_w0 = '0;
    t_fill_addr = 16'hFFFF; t_rdata = '0; t_lat = -1; t_fl = -1; t_done = 0; c_fill = -100;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d; mem_byte_enable = be;
    for (int c = 0; c < 64 && !t_done; c++) begin
      #1;
      t_hits += int'(l1hits_inc);
      t_miss += int'(l1misses_inc);
      g_both |= l2_read & l2_write;
      if (l2_write) begin
        t_wb = 1; t_wb_addr = l2_address; t_wb_w0 = l2_wdata[15:0]; t_ev = eviction;
      end
      if (l2_read) t_fill_addr = l2_address;
      if (mem_resp) begin
        t_rdata = mem_rdata; t_lat = c; t_fl = c - c_fill; t_done = 1;
      end
      if ((l2_read || l2_write) && !l2_resp) begin
        l2_resp = 1'b1;
        l2_rdata = fl(l2_address);
        if (l2_read) c_fill = c;
      end else l2_resp = 1'b0;
      if (!t_done) @(negedge clk);
    end
    chk("xact_done", t_done, 1'b1);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; l2_resp = 1'b0;
    g_hits += t_hits;
    g_miss += t_miss;
  endtask

  task automatic fill_set0;
    xact(1, 0, 16'h0080, 0, 0);
    xact(1, 0, 16'h0100, 0, 0);
    xact(1, 0, 16'h0180, 0, 0);
  endtask

  initial begin
    g_both = 0; g_hits = 0; g_miss = 0;
    #1;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_l2_read", l2_read, 0);
    chk("rst_l2_write", l2_write, 0);
    chk("rst_l2_addr", l2_address, 0);
    chk("rst_evict", eviction, 0);
    chk("rst_miss_pulse", l1misses_inc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    xact(1, 0, 16'h0100, 0, 0);
    chk("m1_miss", t_miss, 1);
    chk("m1_hit", t_hits, 0);
    chk("m1_fill_addr", t_fill_addr, 16'h0100);
    chk("m1_rdata", t_rdata, 16'h1234);
    chk("m1_fill_lat", t_fl, 1);
    chk("m1_no_wb", t_wb, 0);
    xact(1, 0, 16'h0102, 0, 0);
    chk("h1_lat", t_lat, 0);
    chk("h1_hit", t_hits, 1);
    chk("h1_rdata", t_rdata, 16'h1235);
    xact(0, 1, 16'h0100, 16'hBEEF, 2'b10);
    chk("w1_lat", t_lat, 0);
    chk("w1_hit", t_hits, 1);
    xact(1, 0, 16'h0100, 0, 0);
    chk("w1_readback", t_rdata, 16'hBE34);
    xact(1, 1, 16'h0102, 16'h7766, 2'b01);
    chk("rw_lat", t_lat, 0);
    xact(1, 0, 16'h0102, 0, 0);
    chk("rw_readback", t_rdata, 16'h1266);

    do_reset;
    xact(1, 0, 16'h0000, 0, 0);
    chk("s0_fill0", t_fill_addr, 16'h0000);
    fill_set0;
    chk("s0_fill3", t_fill_addr, 16'h0180);
    xact(1, 0, 16'h0200, 0, 0);
    chk("clean_no_wb", t_wb, 0);
    chk("clean_fill", t_fill_addr, 16'h0200);
    chk("clean_rdata", t_rdata, 16'h1334);
    xact(1, 0, 16'h0080, 0, 0);
    chk("plru_keep_0080", t_lat, 0);
    xact(1, 0, 16'h0000, 0, 0);
    chk("plru_0000_miss", t_miss, 1);
    chk("plru_0000_fill", t_fill_addr, 16'h0000);
    xact(1, 0, 16'h0180, 0, 0);
    chk("plru_keep_0180", t_lat, 0);
    xact(1, 0, 16'h0100, 0, 0);
    chk("plru_0100_evicted", t_miss, 1);

    do_reset;
    xact(0, 1, 16'h0000, 16'hAAAA, 2'b11);
    chk("dw_miss", t_miss, 1);
    chk("dw_hit", t_hits, 0);
    fill_set0;
    xact(1, 0, 16'h0200, 0, 0);
    chk("ev_wb", t_wb, 1);
    chk("ev_wb_addr", t_wb_addr, 16'h0000);
    chk("ev_wb_w0", t_wb_w0, 16'hAAAA);
    chk("ev_eviction", t_ev, 1);
    chk("ev_fill", t_fill_addr, 16'h0200);
    xact(1, 0, 16'h0080, 0, 0);
    chk("ev_hit_0080", t_hits, 1);
`ifdef L1_CACHE_STATS_EN
    chk("stat_hits", hit_count, 32'd1);
    chk("stat_miss", miss_count, 32'd5);
    chk("stat_wb", wb_count, 32'd1);
    chk("stat_hits_pulses", hit_count, 32'(g_hits));
    chk("stat_miss_pulses", miss_count, 32'(g_miss));
`endif

    do_reset;
    xact(0, 1, 16'h0000, 16'hAAAA, 2'b11);
    fill_set0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h0200;
    #1;
    for (int c = 0; c < 20 && !l2_write; c++) begin
      @(negedge clk);
      #1;
    end
    chk("rwb_seen", l2_write, 1);
    rst_n = 1'b0;
    #1;
    chk("rwb_l2_write", l2_write, 0);
    chk("rwb_evict", eviction, 0);
    chk("rwb_l2_read", l2_read, 0);
    @(negedge clk);
    mem_read = 1'b0;
    rst_n = 1'b1;
    xact(1, 0, 16'h0000, 0, 0);
    chk("rwb_miss", t_miss, 1);
    chk("rwb_no_wb", t_wb, 0);
    chk("rwb_fill", t_fill_addr, 16'h0000);

    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h0300;
    #1;
    for (int c = 0; c < 20 && !l2_read; c++) begin
      @(negedge clk);
      #1;
    end
    chk("drop_fill_req", l2_read, 1);
    mem_read = 1'b0;
    l2_resp = 1'b1;
    l2_rdata = fl(16'h0300);
    @(negedge clk);
    l2_resp = 1'b0;
    #1;
    chk("drop_no_resp", mem_resp, 0);
    chk("drop_idle", l2_read, 0);
    xact(1, 0, 16'h0300, 0, 0);
    chk("drop_filled_lat", t_lat, 0);
    chk("drop_filled_data", t_rdata, 16'h1434);

    chk("l2_exclusive", g_both, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
